// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter and pending-load scoreboard for the integer register file.
// Optional WB_BYPASS_EN adds byp_rs1_hit/byp_rs2_hit/byp_data forwarding outputs.
module regfile_wb_scheduler #(
    parameter int DBG_STARVE_LIMIT = 8,
    parameter bit SB_EN_X0         = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic [4:0]  dbg_rd,
    input  logic [31:0] dbg_data,
    input  logic        lsu_issue_valid,
    input  logic [4:0]  lsu_issue_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    output logic        hazard,
    output logic        reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
`ifdef WB_BYPASS_EN
    ,
    output logic        byp_rs1_hit,
    output logic        byp_rs2_hit,
    output logic [31:0] byp_data
`endif
);

    localparam logic [7:0] LIM = 8'(DBG_STARVE_LIMIT);

    typedef enum logic {RR_ALU, RR_LSU} rr_t;

    rr_t         rr_q, rr_d;
    logic [7:0]  starve_q, starve_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] set_mask, clr_mask;
    logic        any_grant;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        dbg_ready = 1'b0;
        if (dbg_valid && starve_q == LIM) begin
            dbg_ready = 1'b1;
        end else if (alu_valid && lsu_valid) begin
            alu_ready = (rr_q == RR_ALU);
            lsu_ready = (rr_q == RR_LSU);
        end else if (alu_valid) begin
            alu_ready = 1'b1;
        end else if (lsu_valid) begin
            lsu_ready = 1'b1;
        end else if (dbg_valid) begin
            dbg_ready = 1'b1;
        end
    end

    always_comb begin
        any_grant = 1'b1;
        sel_rd    = 5'd0;
        sel_data  = 32'd0;
        unique case (1'b1)
            alu_ready: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
            end
            lsu_ready: begin
                sel_rd   = lsu_rd;
                sel_data = lsu_data;
            end
            dbg_ready: begin
                sel_rd   = dbg_rd;
                sel_data = dbg_data;
            end
            default: any_grant = 1'b0;
        endcase
    end

    always_comb begin
        rr_d = rr_q;
        if (alu_ready) begin
            rr_d = RR_LSU;
        end else if (lsu_ready) begin
            rr_d = RR_ALU;
        end
        starve_d = starve_q;
        if (!dbg_valid || dbg_ready) begin
            starve_d = 8'd0;
        end else if (starve_q != LIM) begin
            starve_d = starve_q + 8'd1;
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (lsu_issue_valid && (SB_EN_X0 || lsu_issue_rd != 5'd0)) begin
            set_mask = 32'd1 << lsu_issue_rd;
        end
        if (lsu_ready) begin
            clr_mask = 32'd1 << lsu_rd;
        end
        pend_d = (pend_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= RR_ALU;
            starve_q  <= 8'd0;
            pend_q    <= 32'd0;
            reg_write <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'd0;
        end else begin
            rr_q     <= rr_d;
            starve_q <= starve_d;
            pend_q   <= pend_d;
            if (any_grant && sel_rd != 5'd0) begin
                reg_write <= 1'b1;
                wb_rd     <= sel_rd;
                wb_data   <= sel_data;
            end else begin
                reg_write <= 1'b0;
            end
        end
    end

    assign hazard = pend_q[chk_rs1] | pend_q[chk_rs2];

`ifdef WB_BYPASS_EN
    assign byp_rs1_hit = reg_write && (wb_rd == chk_rs1) && (chk_rs1 != 5'd0);
    assign byp_rs2_hit = reg_write && (wb_rd == chk_rs2) && (chk_rs2 != 5'd0);
    assign byp_data    = wb_data;
`endif

    // Reissue is legal only when the same rd retires on this edge.
    issue_not_pending: assert property (
        @(posedge clk) disable iff (rst)
        lsu_issue_valid |->
            (!pend_q[lsu_issue_rd] || (lsu_ready && lsu_rd == lsu_issue_rd))
    );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler.
// Define WB_BYPASS_EN to also exercise the bypass outputs.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        dbg_valid, dbg_ready;
    logic [4:0]  dbg_rd;
    logic [31:0] dbg_data;
    logic        lsu_issue_valid;
    logic [4:0]  lsu_issue_rd;
    logic [4:0]  chk_rs1, chk_rs2;
    logic        hazard;
    logic        reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef WB_BYPASS_EN
    logic        byp_rs1_hit, byp_rs2_hit;
    logic [31:0] byp_data;
`endif

    int passed = 0;
    int total  = 0;

    regfile_wb_scheduler #(
        .DBG_STARVE_LIMIT(8),
        .SB_EN_X0(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .lsu_valid(lsu_valid),
        .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd),
        .lsu_data(lsu_data),
        .dbg_valid(dbg_valid),
        .dbg_ready(dbg_ready),
        .dbg_rd(dbg_rd),
        .dbg_data(dbg_data),
        .lsu_issue_valid(lsu_issue_valid),
        .lsu_issue_rd(lsu_issue_rd),
        .chk_rs1(chk_rs1),
        .chk_rs2(chk_rs2),
        .hazard(hazard),
        .reg_write(reg_write),
        .wb_rd(wb_rd),
        .wb_data(wb_data)
`ifdef WB_BYPASS_EN
        ,
        .byp_rs1_hit(byp_rs1_hit),
        .byp_rs2_hit(byp_rs2_hit),
        .byp_data(byp_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        dbg_valid = 0; dbg_rd = 0; dbg_data = 0;
        lsu_issue_valid = 0; lsu_issue_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_reg_write", reg_write, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_hazard", hazard, 0);
        chk("idle_no_ready", {alu_ready, lsu_ready, dbg_ready}, 0);

        // ALU/LSU contention: ALU, LSU, ALU, LSU
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h22;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("cont_alu_ready", alu_ready, (i % 2 == 0) ? 1 : 0);
            chk("cont_lsu_ready", lsu_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            if (i == 3) begin
                alu_valid = 0;
                lsu_valid = 0;
            end
            chk("cont_reg_write", reg_write, 1);
            chk("cont_wb_rd", wb_rd, (i % 2 == 0) ? 1 : 2);
            chk("cont_wb_data", wb_data, (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        tick();
        chk("cont_idle_reg_write", reg_write, 0);

        // Single ALU write
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        #1;
        chk("alu_ready", alu_ready, 1);
        chk("alu_only_ready", {lsu_ready, dbg_ready}, 0);
        tick();
        alu_valid = 0;
        chk("alu_reg_write", reg_write, 1);
        chk("alu_wb_rd", wb_rd, 3);
        chk("alu_wb_data", wb_data, 32'hDEADBEEF);
        tick();
        chk("alu_reg_write_drop", reg_write, 0);
        chk("alu_wb_rd_hold", wb_rd, 3);
        chk("alu_wb_data_hold", wb_data, 32'hDEADBEEF);

        // Reset mid-grant clears outputs and scoreboard
        lsu_issue_valid = 1; lsu_issue_rd = 5'd12; chk_rs1 = 5'd12;
        tick();
        lsu_issue_valid = 0;
        chk("pre_rst_hazard", hazard, 1);
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h55;
        #1;
        chk("pre_rst_alu_ready", alu_ready, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_reg_write", reg_write, 0);
        chk("async_rst_wb_rd", wb_rd, 0);
        chk("async_rst_wb_data", wb_data, 0);
        chk("async_rst_hazard", hazard, 0);
        tick();
        chk("rst_edge_reg_write", reg_write, 0);
        chk("rst_edge_wb_rd", wb_rd, 0);
        rst = 1'b0; alu_valid = 0; chk_rs1 = 0;
        tick();
        chk("post_rst_reg_write", reg_write, 0);

        // Debug starvation with ALU and LSU always valid
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h22;
        dbg_valid = 1; dbg_rd = 5'd7; dbg_data = 32'h77;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("starve_dbg_wait", dbg_ready, 0);
            tick();
        end
        chk("starve_dbg_ready", dbg_ready, 1);
        chk("starve_others_blocked", {alu_ready, lsu_ready}, 0);
        tick();
        dbg_valid = 0;
        chk("starve_wb_rd", wb_rd, 7);
        chk("starve_wb_data", wb_data, 32'h77);
        chk("starve_rr_resume", alu_ready, 1);
        alu_valid = 0; lsu_valid = 0;
        tick();

        // Lone debug request granted directly
        dbg_valid = 1; dbg_rd = 5'd8; dbg_data = 32'h88;
        #1;
        chk("dbg_alone_ready", dbg_ready, 1);
        tick();
        dbg_valid = 0;
        chk("dbg_alone_reg_write", reg_write, 1);
        chk("dbg_alone_wb_rd", wb_rd, 8);
        tick();

        // Scoreboard set / clear / set-wins
        chk_rs1 = 5'd9;
        lsu_issue_valid = 1; lsu_issue_rd = 5'd9;
        #1;
        chk("sb_hazard_not_yet", hazard, 0);
        tick();
        lsu_issue_valid = 0;
        chk("sb_hazard_set", hazard, 1);
        lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h99;
        #1;
        chk("sb_lsu_ready", lsu_ready, 1);
        chk("sb_hazard_during_accept", hazard, 1);
        tick();
        lsu_valid = 0;
        chk("sb_hazard_cleared", hazard, 0);
        chk("sb_wb_rd", wb_rd, 9);
        chk("sb_wb_data", wb_data, 32'h99);
        lsu_issue_valid = 1;
        tick();
        chk("sb_reissue_hazard", hazard, 1);
        lsu_valid = 1;
        tick();
        lsu_valid = 0; lsu_issue_valid = 0;
        chk("sb_set_wins", hazard, 1);
        chk_rs1 = 0; chk_rs2 = 5'd9;
        #1;
        chk("sb_rs2_hazard", hazard, 1);
        lsu_valid = 1;
        tick();
        lsu_valid = 0;
        chk("sb_rs2_cleared", hazard, 0);
        chk_rs2 = 0;

        // x0 handling
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hABC;
        lsu_issue_valid = 1; lsu_issue_rd = 5'd0;
        #1;
        chk("x0_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0; lsu_issue_valid = 0;
        chk("x0_no_write", reg_write, 0);
        chk("x0_not_pending", hazard, 0);

`ifdef WB_BYPASS_EN
        alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h44;
        chk_rs1 = 5'd0; chk_rs2 = 5'd4;
        tick();
        alu_valid = 0;
        chk("byp_rs2_hit", byp_rs2_hit, 1);
        chk("byp_rs1_miss", byp_rs1_hit, 0);
        chk("byp_data", byp_data, 32'h44);
        chk("byp_no_hazard", hazard, 0);
        tick();
        chk("byp_rs2_drop", byp_rs2_hit, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Owns the single write port of the 32x32 integer register file. It arbitrates writeback requests from three sources: the ALU pipeline, the load/store unit (LSU) returns, and a debug write port. It registers the granted write onto the register file's reg_write/rd/rd_data inputs. It also keeps a pending-load scoreboard so decode can stall on outstanding load destinations.

Parameters:
DBG_STARVE_LIMIT, 8, consecutive cycles debug may wait ungranted before it takes top priority for one grant (legal 1..255)
SB_EN_X0, 0, if 1 x0 is tracked in the scoreboard; if 0 x0 is never marked pending

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request granted this cycle (combinational)
alu_rd  in  5  ALU destination register
alu_data  in  32  ALU result
lsu_valid  in  1  load-return writeback request
lsu_ready  out  1  LSU request granted this cycle (combinational)
lsu_rd  in  5  load destination register
lsu_data  in  32  load data
dbg_valid  in  1  debug write request
dbg_ready  out  1  debug request granted this cycle (combinational)
dbg_rd  in  5  debug destination register
dbg_data  in  32  debug write data
lsu_issue_valid  in  1  load issued; mark destination pending
lsu_issue_rd  in  5  destination of the issued load
chk_rs1  in  5  decode source 1 to check
chk_rs2  in  5  decode source 2 to check
hazard  out  1  chk_rs1 or chk_rs2 is pending (combinational from scoreboard register)
reg_write  out  1  register-file write enable (registered)
wb_rd  out  5  register-file write address (registered)
wb_data  out  32  register-file write data (registered)

Behaviour:
- Reset, asynchronous, any cycle: reg_write=0, wb_rd=0, wb_data=0, scoreboard cleared, round-robin pointer=ALU, starve counter=0.
- Reset mid-operation drops all pending bits and any in-flight registered write. No write occurs on the reset edge.
- Handshake: a transfer happens when valid&&ready in the same cycle. At most one ready is high per cycle. ready is never high without its valid.
  - Requesters hold rd/data stable until accepted.
  - Dropping valid before it is accepted is allowed.
- Priority:
  1. Debug, if its starve counter equals DBG_STARVE_LIMIT.
  2. ALU vs LSU round-robin. When both are valid, grant the one not granted last time between them. A single valid one is granted directly.
  3. Debug otherwise.
- Round-robin pointer: updates only on an ALU or LSU grant.
- Starve counter:
  - Increments each cycle dbg_valid=1 and dbg_ready=0, saturating at DBG_STARVE_LIMIT.
  - Clears on a debug grant or when dbg_valid=0.
- Latency: an accepted request appears on reg_write/wb_rd/wb_data at the next rising edge, so one cycle of latency.
  - reg_write=1 for exactly one cycle per accepted request whose rd!=0.
  - With no grant, reg_write=0 and wb_rd/wb_data hold their previous values.
- rd=0: accepted normally (ready asserts), but reg_write stays 0.
- Scoreboard (pend[31:0]):
  - lsu_issue_valid sets pend[lsu_issue_rd]. The bit is not set for rd=0 when SB_EN_X0=0.
  - An LSU accept clears pend[lsu_rd] at the same edge the write is registered.
  - Set and clear of the same rd in the same cycle: set wins.
  - ALU and debug writes never touch the scoreboard.
- hazard = pend[chk_rs1] | pend[chk_rs2], from the registered pend. A bit cleared by an LSU accept de-asserts hazard the cycle after that accept.
- Caller obligation, checked by an assertion: no lsu_issue_valid to an rd that is already pending.
- Throughput: one write per cycle sustained. Back-to-back grants to the same requester are allowed.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: adds outputs byp_rs1_hit, byp_rs2_hit (1 bit) and byp_data (32 bits).
  - byp_rsN_hit=1 when reg_write=1 and wb_rd==chk_rsN (nonzero).
  - byp_data=wb_data.
  - hazard is unaffected.
- Undefined: these ports do not exist and no comparison logic is built.

Test Plan:
- Reset: assert rst asynchronously mid-grant with alu_valid=1, alu_rd=5 -> reg_write=0, wb_rd=0, wb_data=0 immediately; pend=0; no write of x5 on the next edge.
- Single ALU write: alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle reg_write=1, wb_rd=3, wb_data=0xDEADBEEF; the following cycle reg_write=0.
- ALU/LSU contention: both valid for 4 cycles (alu_rd=1, lsu_rd=2) -> grant order ALU, LSU, ALU, LSU; each grant appears on wb_rd one cycle later.
- Debug starvation: dbg_valid=1 (rd=7) with ALU and LSU continuously valid, DBG_STARVE_LIMIT=8 -> dbg_ready=1 on the 9th cycle; wb_rd=7 the cycle after.
- Scoreboard: lsu_issue_valid, rd=9; chk_rs1=9 -> hazard=1 from the next cycle; LSU return rd=9 accepted -> hazard=0 the cycle after acceptance. Same-cycle issue and return of rd=9 -> pend[9] stays 1.
- x0 handling: alu_rd=0 valid -> alu_ready=1, reg_write stays 0. With WB_BYPASS_EN, alu_rd=4 and chk_rs2=4 -> byp_rs2_hit=1 in the reg_write cycle.
